spike_window_decoder: RTL and testbench

- Output stage of the spiking pipeline: sits directly downstream of the two-neuron LIF chain and consumes its per-neuron spike outputs (spike_out1, spike_out2 packed as spike_in[1:0]).
- Counts spikes per neuron over a fixed presentation window, then sequentially scans the counts to pick the most active neuron (rate-coded decision).
- Presents the result with a valid/ready handshake to the downstream consumer (host or next layer).

---
 rtl/spike_window_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_spike_window_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_window_decoder.sv
// spike_window_decoder
// Rate-coded output stage for the spiking pipeline. Counts spikes per neuron
// over a fixed window of WINDOW_CYCLES samples. It then scans the counts one
// neuron per cycle to find the most active neuron. The lowest index wins a tie.
// The result is offered with a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        request a new window (taken only when idle)
//   spike_in     per-neuron spike inputs, sampled while counting
//   result_ready consumer accepts the result while result_valid is high
//   busy         window in progress or result pending
//   result_valid result available
//   winner_idx   index of the most active neuron
//   winner_count spike count of the winner
//   no_spike     every neuron counted zero spikes
//   counts_flat  neuron i count in bits [i*CNT_WIDTH +: CNT_WIDTH]
module spike_window_decoder #(
    parameter int NUM_NEURONS   = 2,
    parameter int WINDOW_CYCLES = 100,
    parameter int CNT_WIDTH     = 8,
    parameter int IDX_WIDTH     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_NEURONS-1:0]           spike_in,
    input  logic                             result_ready,
    output logic                             busy,
    output logic                             result_valid,
    output logic [IDX_WIDTH-1:0]             winner_idx,
    output logic [CNT_WIDTH-1:0]             winner_count,
    output logic                             no_spike,
    output logic [NUM_NEURONS*CNT_WIDTH-1:0] counts_flat
);

    // The window counter runs 0..WINDOW_CYCLES-1
    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] SCAN_LAST = IDX_WIDTH'(NUM_NEURONS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_WIDTH-1:0]   cnt_r [NUM_NEURONS];
    logic [WIN_W-1:0]       win_cnt_r;
    logic [IDX_WIDTH-1:0]   scan_idx_r;
    logic [IDX_WIDTH-1:0]   winner_idx_r;
    logic [CNT_WIDTH-1:0]   winner_count_r;
    logic                   no_spike_r;
    logic                   busy_r;
    logic                   result_valid_r;

    logic                   win_last_s;
    logic                   scan_last_s;
    logic [CNT_WIDTH-1:0]   cand_cnt_s;
    logic                   take_s;
    logic [CNT_WIDTH-1:0]   best_cnt_nxt_s;

    // Saturating increment: a full counter stays at its maximum and never wraps
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        logic [CNT_WIDTH-1:0] r;
        if (en && (v != CNT_MAX)) begin
            r = v + CNT_WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Scan helpers: end-of-window, end-of-scan, and the running-best update
    always_comb begin
        win_last_s     = (win_cnt_r == WIN_LAST);
        scan_last_s    = (scan_idx_r == SCAN_LAST);
        cand_cnt_s     = cnt_r[scan_idx_r];
        // A strict compare keeps the earlier (lower) index when counts tie
        take_s         = (cand_cnt_s > winner_count_r);
        if (take_s) begin
            best_cnt_nxt_s = cand_cnt_s;
        end else begin
            best_cnt_nxt_s = winner_count_r;
        end
    end

    // Next-state logic of the window FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_COUNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (win_last_s) begin
                    state_nxt_s = ST_COMPARE;
                end else begin
                    state_nxt_s = ST_COUNT;
                end
            end
            ST_COMPARE: begin
                if (scan_last_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_COMPARE;
                end
            end
            ST_HOLD: begin
                if (result_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, plus the status flags registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            result_valid_r <= (state_nxt_s == ST_HOLD);
        end
    end

    // Datapath: spike counters, window counter, scan index and running best
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cnt_r[i] <= {CNT_WIDTH{1'b0}};
            end
            win_cnt_r      <= {WIN_W{1'b0}};
            scan_idx_r     <= {IDX_WIDTH{1'b0}};
            winner_idx_r   <= {IDX_WIDTH{1'b0}};
            winner_count_r <= {CNT_WIDTH{1'b0}};
            no_spike_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            cnt_r[i] <= {CNT_WIDTH{1'b0}};
                        end
                        win_cnt_r      <= {WIN_W{1'b0}};
                        scan_idx_r     <= {IDX_WIDTH{1'b0}};
                        winner_idx_r   <= {IDX_WIDTH{1'b0}};
                        winner_count_r <= {CNT_WIDTH{1'b0}};
                        no_spike_r     <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        cnt_r[i] <= sat_inc(cnt_r[i], spike_in[i]);
                    end
                    win_cnt_r <= win_cnt_r + WIN_W'(1);
                    if (win_last_s) begin
                        scan_idx_r     <= {IDX_WIDTH{1'b0}};
                        winner_idx_r   <= {IDX_WIDTH{1'b0}};
                        winner_count_r <= {CNT_WIDTH{1'b0}};
                    end
                end
                ST_COMPARE: begin
                    if (take_s) begin
                        winner_idx_r <= scan_idx_r;
                    end
                    winner_count_r <= best_cnt_nxt_s;
                    if (scan_last_s) begin
                        scan_idx_r <= {IDX_WIDTH{1'b0}};
                        no_spike_r <= (best_cnt_nxt_s == {CNT_WIDTH{1'b0}});
                    end else begin
                        scan_idx_r <= scan_idx_r + IDX_WIDTH'(1);
                    end
                end
                ST_HOLD: begin
                    // Result is frozen until the consumer takes it
                end
                default: begin
                    win_cnt_r <= {WIN_W{1'b0}};
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_NEURONS; g++) begin : g_flat
            assign counts_flat[g*CNT_WIDTH +: CNT_WIDTH] = cnt_r[g];
        end
    endgenerate

    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign winner_idx   = winner_idx_r;
    assign winner_count = winner_count_r;
    assign no_spike     = no_spike_r;

endmodule

// File: tb/tb_spike_window_decoder.sv
// Bench for spike_window_decoder. Two instances share the same stimulus:
// one has 8-bit counters and one has 2-bit counters, which exercises
// saturation. A window-level model predicts the outputs of both instances.
// A negedge process compares the outputs against that prediction every cycle.
module tb_spike_window_decoder;

    localparam int N    = 2;
    localparam int W    = 10;
    localparam int CWA  = 8;
    localparam int CWB  = 2;
    localparam int IW   = 1;
    localparam int MAXA = (1 << CWA) - 1;
    localparam int MAXB = (1 << CWB) - 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   spike_in;
    logic           result_ready;

    logic           busy_a, valid_a, nos_a;
    logic [IW-1:0]  idx_a;
    logic [CWA-1:0] wc_a;
    logic [N*CWA-1:0] flat_a;
    logic           busy_b, valid_b, nos_b;
    logic [IW-1:0]  idx_b;
    logic [CWB-1:0] wc_b;
    logic [N*CWB-1:0] flat_b;

    spike_window_decoder #(.NUM_NEURONS(N), .WINDOW_CYCLES(W), .CNT_WIDTH(CWA), .IDX_WIDTH(IW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .result_ready(result_ready),
        .busy(busy_a), .result_valid(valid_a), .winner_idx(idx_a), .winner_count(wc_a),
        .no_spike(nos_a), .counts_flat(flat_a));

    spike_window_decoder #(.NUM_NEURONS(N), .WINDOW_CYCLES(W), .CNT_WIDTH(CWB), .IDX_WIDTH(IW)) dut_b (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .result_ready(result_ready),
        .busy(busy_b), .result_valid(valid_b), .winner_idx(idx_b), .winner_count(wc_b),
        .no_spike(nos_b), .counts_flat(flat_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window-level expectations
    bit check_en;
    bit exp_busy, exp_valid, exp_known;
    int exp_cnt_a [N];
    int exp_cnt_b [N];
    int exp_idx_a, exp_wc_a, exp_idx_b, exp_wc_b;
    bit exp_nos_a, exp_nos_b;
    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*CWA-1:0] pack_a();
        logic [N*CWA-1:0] v;
        for (int i = 0; i < N; i++) v[i*CWA +: CWA] = exp_cnt_a[i][CWA-1:0];
        return v;
    endfunction

    function automatic logic [N*CWB-1:0] pack_b();
        logic [N*CWB-1:0] v;
        for (int i = 0; i < N; i++) v[i*CWB +: CWB] = exp_cnt_b[i][CWB-1:0];
        return v;
    endfunction

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy_a", {31'd0, busy_a}, {31'd0, exp_busy});
            chk("busy_b", {31'd0, busy_b}, {31'd0, exp_busy});
            chk("valid_a", {31'd0, valid_a}, {31'd0, exp_valid});
            chk("valid_b", {31'd0, valid_b}, {31'd0, exp_valid});
            chk("counts_a", 32'(flat_a), 32'(pack_a()));
            chk("counts_b", 32'(flat_b), 32'(pack_b()));
            if (exp_known) begin
                chk("idx_a", 32'(idx_a), exp_idx_a);
                chk("wc_a", 32'(wc_a), exp_wc_a);
                chk("nos_a", {31'd0, nos_a}, {31'd0, exp_nos_a});
                chk("idx_b", 32'(idx_b), exp_idx_b);
                chk("wc_b", 32'(wc_b), exp_wc_b);
                chk("nos_b", {31'd0, nos_b}, {31'd0, exp_nos_b});
            end
        end
    end

    task automatic model_all_zero();
        exp_busy = 1'b0; exp_valid = 1'b0; exp_known = 1'b1;
        for (int i = 0; i < N; i++) begin exp_cnt_a[i] = 0; exp_cnt_b[i] = 0; end
        exp_idx_a = 0; exp_wc_a = 0; exp_nos_a = 1'b0;
        exp_idx_b = 0; exp_wc_b = 0; exp_nos_b = 1'b0;
    endtask

    // Winner = highest count, earliest index on a tie
    task automatic model_decide();
        exp_idx_a = 0; exp_wc_a = 0; exp_idx_b = 0; exp_wc_b = 0;
        for (int i = 0; i < N; i++) begin
            if (exp_cnt_a[i] > exp_wc_a) begin exp_wc_a = exp_cnt_a[i]; exp_idx_a = i; end
            if (exp_cnt_b[i] > exp_wc_b) begin exp_wc_b = exp_cnt_b[i]; exp_idx_b = i; end
        end
        exp_nos_a = (exp_wc_a == 0);
        exp_nos_b = (exp_wc_b == 0);
    endtask

    task automatic do_start(input logic [N-1:0] pre);
        start = 1'b1; spike_in = pre;
        @(posedge clk); #1;
        start = 1'b0;
        model_all_zero();
        exp_busy = 1'b1;
    endtask

    task automatic do_sample(input logic [N-1:0] bits, input bit last);
        spike_in = bits;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            exp_cnt_a[i] = (exp_cnt_a[i] + int'(bits[i]) > MAXA) ? MAXA : exp_cnt_a[i] + int'(bits[i]);
            exp_cnt_b[i] = (exp_cnt_b[i] + int'(bits[i]) > MAXB) ? MAXB : exp_cnt_b[i] + int'(bits[i]);
        end
        if (last) exp_known = 1'b0;
    endtask

    task automatic run_window(input logic [W-1:0] p0, input logic [W-1:0] p1,
                              input logic [N-1:0] pre, input logic [N-1:0] post,
                              input int hold, input bit pulse);
        do_start(pre);
        for (int s = 0; s < W; s++) do_sample({p1[s], p0[s]}, s == W - 1);
        spike_in = post;
        for (int c = 0; c < N; c++) begin
            @(posedge clk); #1;
            if (c == N - 1) begin
                model_decide();
                exp_known = 1'b1;
                exp_valid = 1'b1;
            end
        end
        for (int c = 0; c < hold; c++) begin
            start = pulse && (c % 5 == 2);
            @(posedge clk); #1;
        end
        // Handshake edge; a start arriving together with it must be dropped
        result_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0; start = 1'b0; spike_in = '0;
        exp_busy = 1'b0; exp_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; check_en = 1'b0;
        rst = 1'b0; start = 1'b0; spike_in = '0; result_ready = 1'b0;
        model_all_zero();
        #2 check_en = 1'b1;
        #21 rst = 1'b1;
        @(posedge clk); #1;

        // Neuron1 more active: 3 vs 5, plus 20 cycles of backpressure with start pulses
        run_window(10'b0000010101, 10'b1011001001, 2'b00, 2'b00, 20, 1'b1);
        chk("t1_idx", 32'(idx_a), 32'd1);
        chk("t1_wc", 32'(wc_a), 32'd5);
        chk("t1_counts", 32'(flat_a), 32'h0503);
        chk("t1_nos", {31'd0, nos_a}, 32'd0);
        chk("t1_busy_after_hs", {31'd0, busy_a}, 32'd0);

        // Tie at 4; spikes on the start edge and the first scan edge are ignored
        run_window(10'b1111000000, 10'b0000001111, 2'b11, 2'b11, 2, 1'b0);
        chk("t2_idx", 32'(idx_a), 32'd0);
        chk("t2_wc", 32'(wc_a), 32'd4);
        chk("t2_counts", 32'(flat_a), 32'h0404);

        // Saturation on the 2-bit instance: 10 -> 3, 2 stays 2
        run_window(10'b1111111111, 10'b0100000100, 2'b00, 2'b00, 1, 1'b0);
        chk("t3_wc_b", 32'(wc_b), 32'd3);
        chk("t3_idx_b", 32'(idx_b), 32'd0);
        chk("t3_counts_b", 32'(flat_b), 32'hB);
        chk("t3_wc_a", 32'(wc_a), 32'd10);

        // No activity
        run_window(10'b0, 10'b0, 2'b00, 2'b00, 3, 1'b0);
        chk("t4_nos", {31'd0, nos_a}, 32'd1);
        chk("t4_wc", 32'(wc_a), 32'd0);
        chk("t4_idx", 32'(idx_a), 32'd0);

        // Reset in the middle of a window, seen without a clock edge
        do_start(2'b00);
        for (int s = 0; s < 5; s++) do_sample(2'b11, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_counts", 32'(flat_a), 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_wc", 32'(wc_a), 32'd0);
        model_all_zero();
        spike_in = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        run_window(10'b0000000111, 10'b0011111111, 2'b00, 2'b00, 1, 1'b0);
        chk("t5_idx", 32'(idx_a), 32'd1);
        chk("t5_wc", 32'(wc_a), 32'd8);
        chk("t5_counts", 32'(flat_a), 32'h0803);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
